// File: rtl/arbiter_rr_lock_if.sv
// Request/lock/grant bundle for the round-robin lock arbiter.
// master drives req/lock and observes the grant; slave is the arbiter side.
interface arbiter_rr_lock_if #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
);

  logic [N-1:0]     req;
  logic [N-1:0]     lock;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  modport master (
    output req,
    output lock,
    input  grant,
    input  grant_valid,
    input  grant_idx
  );

  modport slave (
    input  req,
    input  lock,
    output grant,
    output grant_valid,
    output grant_idx
  );

endinterface

// File: rtl/arbiter_rr_lock.sv
// N-way round-robin arbiter with registered one-hot grant and per-requester burst lock.
// Define ARB_HOLD_TIMEOUT_EN to bound a locked hold to MAX_HOLD cycles when others wait.
module arbiter_rr_lock #(
  parameter int N        = 4,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  arbiter_rr_lock_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int unsigned N_U = N;

  if (N < 2) begin : g_bad_n
    $error("arbiter_rr_lock: N must be >= 2");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("arbiter_rr_lock: MAX_HOLD must be >= 2");
  end

  // Modular increment without a divider; base and ofs are both below N, so one
  // conditional subtraction is enough and the result never reaches N.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] base,
                                                 input int unsigned     ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    if (sum >= N_U) sum = sum - N_U;
    return IDX_W'(sum);
  endfunction

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     grant_q;
  logic             grant_valid_q;
  logic [IDX_W-1:0] grant_idx_q;

  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic             hold;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD) + 1;

  logic [HC_W-1:0] hold_cnt;
  logic            at_limit;
  logic            others_req;

  assign at_limit   = (hold_cnt == HC_W'(MAX_HOLD - 1));
  assign others_req = |(bus.req & ~grant_q);
`endif

  // Priority search starting at ptr; the first requester found wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no
    // path leaves it unassigned and no latch is inferred.
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && bus.req[wrap_inc(ptr, i)]) begin
        found   = 1'b1;
        win_idx = wrap_inc(ptr, i);
      end
    end
  end

  // A grant is held only while its owner keeps both req and lock high.
  always_comb begin
    hold = 1'b0;
    if (state == ST_GRANT && bus.req[grant_idx_q] && bus.lock[grant_idx_q]) begin
      hold = 1'b1;
    end
`ifdef ARB_HOLD_TIMEOUT_EN
    if (hold && at_limit && others_req) begin
      hold = 1'b0;
    end
`endif
  end

  // Release and new arbitration resolve in the same edge, so back-to-back
  // grants have no idle bubble; ptr only moves when a new winner is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
    end else if (hold) begin
      state <= ST_GRANT;
    end else if (found) begin
      state         <= ST_GRANT;
      grant_q       <= {{(N-1){1'b0}}, 1'b1} << win_idx;
      grant_valid_q <= 1'b1;
      grant_idx_q   <= win_idx;
      ptr           <= wrap_inc(win_idx, 1);
    end else begin
      state         <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  // Counts hold cycles of the current grant; saturates at the limit so a lone
  // locked requester keeps its grant indefinitely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (hold) begin
      if (!at_limit) hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_arbiter_rr_lock.sv
// Directed bench for arbiter_rr_lock: a 4-way instance (MAX_HOLD=4) and a 5-way
// instance, with expectations written by hand for both timeout builds.
module tb_arbiter_rr_lock;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  arbiter_rr_lock_if #(.N(4)) bus_a ();
  arbiter_rr_lock_if #(.N(5)) bus_b ();

  arbiter_rr_lock #(.N(4), .MAX_HOLD(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  arbiter_rr_lock #(.N(5), .MAX_HOLD(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] eg, input logic [1:0] ei);
    check({tag, ".grant"}, 32'(bus_a.grant), 32'(eg));
    check({tag, ".valid"}, 32'(bus_a.grant_valid), 32'(|eg));
    check({tag, ".idx"}, 32'(bus_a.grant_idx), 32'(ei));
  endtask

  task automatic chk_b(input string tag, input logic [4:0] eg, input logic [2:0] ei);
    check({tag, ".grant"}, 32'(bus_b.grant), 32'(eg));
    check({tag, ".valid"}, 32'(bus_b.grant_valid), 32'(|eg));
    check({tag, ".idx"}, 32'(bus_b.grant_idx), 32'(ei));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] e;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus_a.req   = '0;
    bus_a.lock  = '0;
    bus_b.req   = '0;
    bus_b.lock  = '0;

    repeat (2) @(negedge clk);
    chk_a("reset_a", 4'b0000, 2'd0);
    chk_b("reset_b", 5'b00000, 3'd0);
    rst_n = 1'b1;

    // Locked burst, then asynchronous reset between edges.
    bus_a.req  = 4'b1000;
    bus_a.lock = 4'b1000;
    tick();
    chk_a("burst_start", 4'b1000, 2'd3);
    tick();
    chk_a("burst_hold", 4'b1000, 2'd3);
    #2 rst_n = 1'b0;
    #1 chk_a("async_reset", 4'b0000, 2'd0);
    bus_a.req  = '0;
    bus_a.lock = '0;
    @(negedge clk);
    rst_n = 1'b1;

    bus_a.req = 4'b1000;
    tick();
    chk_a("post_reset_req3", 4'b1000, 2'd3);
    bus_a.req = 4'b0000;
    tick();
    chk_a("idle_after_release", 4'b0000, 2'd0);

    // Plain rotation, ptr starts at 0.
    bus_a.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = 4'b0001 << (i % 4);
      chk_a($sformatf("rotate%0d", i), e, 2'(i % 4));
    end

    // Lock hold while requester 1 waits.
    bus_a.req  = 4'b0011;
    bus_a.lock = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a($sformatf("lock_hold%0d", i), 4'b0001, 2'd0);
    end
    tick();
`ifdef ARB_HOLD_TIMEOUT_EN
    chk_a("timeout_release", 4'b0010, 2'd1);
`else
    chk_a("lock_hold4", 4'b0001, 2'd0);
    bus_a.lock = 4'b0000;
    tick();
    chk_a("unlock_next", 4'b0010, 2'd1);
`endif
    // ptr is now 2: requester 2 comes first from a full request vector.
    bus_a.req  = 4'b1111;
    bus_a.lock = 4'b0000;
    tick();
    chk_a("ptr_after_release", 4'b0100, 2'd2);

    // Lone locked requester keeps the grant in either build.
    bus_a.req  = 4'b0001;
    bus_a.lock = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_a($sformatf("lone_hold%0d", i), 4'b0001, 2'd0);
    end

    // Owner drops req with lock still high: grant goes idle.
    bus_a.req = 4'b0000;
    tick();
    chk_a("drop_idle", 4'b0000, 2'd0);
    bus_a.lock = 4'b1111;
    tick();
    chk_a("lock_without_req", 4'b0000, 2'd0);
    bus_a.lock = 4'b0000;

    // Non-power-of-two wrap on the 5-way instance.
    bus_b.req = 5'b01000;
    tick();
    chk_b("n5_set_ptr4", 5'b01000, 3'd3);
    bus_b.req = 5'b10001;
    tick();
    chk_b("n5_wrap0", 5'b10000, 3'd4);
    tick();
    chk_b("n5_wrap1", 5'b00001, 3'd0);
    tick();
    chk_b("n5_wrap2", 5'b10000, 3'd4);
    tick();
    chk_b("n5_wrap3", 5'b00001, 3'd0);
    bus_b.req = 5'b00000;
    tick();
    chk_b("n5_idle", 5'b00000, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
